// File: rtl/mpmc10_rd_data_collect.sv
// Packs strip-burst read beats into one line buffer and hands the finished line,
// tagged with its 16-byte-aligned base address, to the fill logic over valid/ack.
module mpmc10_rd_data_collect #(
  parameter int MAX_STRIPS = 4,
  parameter int SW         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [5:0]                num_strips,
  input  logic [31:0]               addr_base,
  input  logic                      rd_data_valid,
  input  logic [127:0]              rd_data,
  input  logic                      line_ack,
  output logic                      line_valid,
  output logic [MAX_STRIPS*128-1:0] line_data,
  output logic [31:0]               line_addr,
  output logic                      busy,
  output logic [5:0]                strip_cnt,
  output logic                      overrun
);

  localparam logic [5:0] LAST_MAX = 6'(MAX_STRIPS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state;
  logic [5:0] last;

  // Requests for more strips than the buffer holds saturate to the final slot.
  function automatic logic [5:0] sat_last(input logic [5:0] n);
    return (n > LAST_MAX) ? LAST_MAX : n;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= '0;
      strip_cnt  <= '0;
      line_valid <= 1'b0;
      overrun    <= 1'b0;
      line_data  <= '0;
      line_addr  <= 32'h1FFF_FFF0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_data_valid)
            overrun <= 1'b1;
          if (start) begin
            last      <= sat_last(num_strips);
            line_addr <= {addr_base[31:4], 4'h0};
            strip_cnt <= '0;
            line_data <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (rd_data_valid) begin
            line_data[32'(strip_cnt[SW-1:0]) * 128 +: 128] <= rd_data;
            strip_cnt <= strip_cnt + 6'd1;
            if (strip_cnt == last) begin
              line_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          // Line stays frozen until the consumer takes it; stray beats are flagged.
          if (rd_data_valid)
            overrun <= 1'b1;
          if (line_ack) begin
            line_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          line_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc10_rd_data_collect.sv
// Directed bench for mpmc10_rd_data_collect with hand-built expected lines.
module tb_mpmc10_rd_data_collect;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   num_strips;
  logic [31:0]  addr_base;
  logic         rd_data_valid;
  logic [127:0] rd_data;
  logic         line_ack;
  logic         line_valid;
  logic [511:0] line_data;
  logic [31:0]  line_addr;
  logic         busy;
  logic [5:0]   strip_cnt;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  mpmc10_rd_data_collect #(.MAX_STRIPS(4), .SW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_strips(num_strips),
    .addr_base(addr_base), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .line_ack(line_ack), .line_valid(line_valid), .line_data(line_data),
    .line_addr(line_addr), .busy(busy), .strip_cnt(strip_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int k);
    return {32'hA000_0000 + 32'(k), 32'hB100_0000 + 32'(k), 32'hC200_0000 + 32'(k), 32'hD300_0000 + 32'(k)};
  endfunction

  task automatic beat(input logic [127:0] d);
    rd_data_valid = 1'b1;
    rd_data       = d;
    tick();
    rd_data_valid = 1'b0;
    rd_data       = '0;
  endtask

  task automatic go(input logic [5:0] n, input logic [31:0] a);
    start      = 1'b1;
    num_strips = n;
    addr_base  = a;
    tick();
    start = 1'b0;
  endtask

  task automatic ack();
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_strips = '0; addr_base = '0;
    rd_data_valid = 1'b0; rd_data = '0; line_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 512'(line_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_cnt", 512'(strip_cnt), 512'd0);
    chk("rst_ovr", 512'(overrun), 512'd0);
    chk("rst_data", line_data, 512'd0);
    chk("rst_addr", 512'(line_addr), 512'h1FFF_FFF0);

    // 1: four back-to-back beats
    go(6'd3, 32'h1234_5678);
    chk("t1_busy", 512'(busy), 512'd1);
    beat(pat(1)); beat(pat(2)); beat(pat(3));
    chk("t1_valid_early", 512'(line_valid), 512'd0);
    beat(pat(4));
    chk("t1_valid", 512'(line_valid), 512'd1);
    chk("t1_data", line_data, {pat(4), pat(3), pat(2), pat(1)});
    chk("t1_addr", 512'(line_addr), 512'h1234_5670);
    chk("t1_ovr", 512'(overrun), 512'd0);
    chk("t1_cnt", 512'(strip_cnt), 512'd4);
    ack();
    chk("t1_ack_valid", 512'(line_valid), 512'd0);
    chk("t1_ack_busy", 512'(busy), 512'd0);
    chk("t1_cnt_hold", 512'(strip_cnt), 512'd4);

    // 2: single strip held without ack
    go(6'd0, 32'h0000_0100);
    chk("t2_cnt_clr", 512'(strip_cnt), 512'd0);
    beat(pat(9));
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 512'(line_valid), 512'd1);
      chk("t2_hold_data", line_data, {384'd0, pat(9)});
      tick();
    end
    ack();
    chk("t2_ack_busy", 512'(busy), 512'd0);
    chk("t2_ack_valid", 512'(line_valid), 512'd0);

    // 3: two beats with idle gaps
    go(6'd1, 32'h0000_2000);
    chk("t3_cnt0", 512'(strip_cnt), 512'd0);
    beat(pat(5));
    chk("t3_cnt1", 512'(strip_cnt), 512'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_gap_valid", 512'(line_valid), 512'd0);
      tick();
    end
    beat(pat(6));
    chk("t3_cnt2", 512'(strip_cnt), 512'd2);
    chk("t3_valid", 512'(line_valid), 512'd1);
    chk("t3_data", line_data, {256'd0, pat(6), pat(5)});
    ack();

    // 4: stray beat in IDLE, then start during COLLECT
    beat(pat(7));
    chk("t4_ovr", 512'(overrun), 512'd1);
    go(6'd3, 32'hAAAA_0000);
    beat(pat(10));
    go(6'd0, 32'h5555_0000);
    chk("t4_busy", 512'(busy), 512'd1);
    chk("t4_valid", 512'(line_valid), 512'd0);
    chk("t4_cnt", 512'(strip_cnt), 512'd1);
    beat(pat(11)); beat(pat(12)); beat(pat(13));
    chk("t4_done", 512'(line_valid), 512'd1);
    chk("t4_addr", 512'(line_addr), 512'hAAAA_0000);
    chk("t4_data", line_data, {pat(13), pat(12), pat(11), pat(10)});
    chk("t4_ovr_sticky", 512'(overrun), 512'd1);
    // start together with ack in DONE: ack wins, start dropped
    start = 1'b1; num_strips = 6'd0; addr_base = 32'h7777_0000;
    ack();
    start = 1'b0;
    chk("t4_start_drop", 512'(busy), 512'd0);

    // 5: clamp of num_strips, fifth beat overruns
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_ovr_clr", 512'(overrun), 512'd0);
    go(6'd9, 32'h0000_4000);
    beat(pat(20)); beat(pat(21)); beat(pat(22)); beat(pat(23));
    chk("t5_done", 512'(line_valid), 512'd1);
    chk("t5_ovr0", 512'(overrun), 512'd0);
    beat(pat(24));
    chk("t5_ovr1", 512'(overrun), 512'd1);
    chk("t5_data", line_data, {pat(23), pat(22), pat(21), pat(20)});
    chk("t5_cnt", 512'(strip_cnt), 512'd4);
    ack();

    // 6: reset mid-burst, then a clean burst
    go(6'd3, 32'h0000_8000);
    beat(pat(30)); beat(pat(31));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid", 512'(line_valid), 512'd0);
    chk("t6_busy", 512'(busy), 512'd0);
    chk("t6_cnt", 512'(strip_cnt), 512'd0);
    chk("t6_data", line_data, 512'd0);
    go(6'd3, 32'h0000_9010);
    beat(pat(40)); beat(pat(41)); beat(pat(42)); beat(pat(43));
    chk("t6_new_valid", 512'(line_valid), 512'd1);
    chk("t6_new_data", line_data, {pat(43), pat(42), pat(41), pat(40)});
    chk("t6_new_addr", 512'(line_addr), 512'h0000_9010);
    ack();
    chk("t6_idle", 512'(busy), 512'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
